// File: rtl/vga_interface.sv
// VGA 640x480 @ 60 Hz timing generator: pixel/line counters, active-low syncs and a
// blanked color output stage, all advancing only on pixel-enabled clock edges.
module vga_interface #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        DOWNCOUNTER,
   input  logic [11:0] COLOR_IN,
   output logic [9:0]  ADDRH,
   output logic [8:0]  ADDRV,
   output logic [11:0] COLOR_OUT,
   output logic        HS,
   output logic        VS,
   output logic        REFRESH
);
   localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

   logic [9:0]  hcnt_r;
   logic [9:0]  vcnt_r;
   logic [11:0] color_r;
   logic        hs_r;
   logic        vs_r;
   logic        refresh_r;
   logic        visible_s;
   logic        hs_next_s;
   logic        vs_next_s;
   logic        line_end_s;
   logic        frame_end_s;

   // Position decode of the pixel currently addressed by the counters
   always_comb begin
      visible_s   = (hcnt_r < H_VIS) && (vcnt_r < V_VIS);
      hs_next_s   = ~((hcnt_r >= HS_START) && (hcnt_r <= HS_END));
      vs_next_s   = ~((vcnt_r >= VS_START) && (vcnt_r <= VS_END));
      line_end_s  = (hcnt_r == H_LAST);
      frame_end_s = line_end_s && (vcnt_r == V_LAST);
   end

   // Horizontal and vertical position counters
   always_ff @(posedge CLK) begin
      if (RST) begin
         hcnt_r <= 10'd0;
         vcnt_r <= 10'd0;
      end else if (DOWNCOUNTER) begin
         if (line_end_s) begin
            hcnt_r <= 10'd0;
            vcnt_r <= frame_end_s ? 10'd0 : vcnt_r + 10'd1;
         end else begin
            hcnt_r <= hcnt_r + 10'd1;
         end
      end else begin
         hcnt_r <= hcnt_r;
         vcnt_r <= vcnt_r;
      end
   end

   // Output stage: color, syncs and frame pulse for the pixel just addressed
   always_ff @(posedge CLK) begin
      if (RST) begin
         color_r   <= 12'h000;
         hs_r      <= 1'b1;
         vs_r      <= 1'b1;
         refresh_r <= 1'b0;
      end else if (DOWNCOUNTER) begin
         color_r   <= visible_s ? COLOR_IN : 12'h000;
         hs_r      <= hs_next_s;
         vs_r      <= vs_next_s;
         refresh_r <= frame_end_s;
      end else begin
         color_r   <= color_r;
         hs_r      <= hs_r;
         vs_r      <= vs_r;
         refresh_r <= 1'b0;
      end
   end

   assign ADDRH     = hcnt_r;
   assign ADDRV     = vcnt_r[8:0];
   assign COLOR_OUT = color_r;
   assign HS        = hs_r;
   assign VS        = vs_r;
   assign REFRESH   = refresh_r;
endmodule

// File: tb/tb_vga_interface.sv
// Bench for vga_interface: a full-size and a reduced-timing instance share stimulus;
// a pixel-index model feeds per-cycle scoreboards, plus directed sync/frame checks.
module tb_vga_interface;
   typedef struct packed {
      logic [9:0]  h;
      logic [8:0]  v;
      logic [11:0] c;
      logic        hs;
      logic        vs;
      logic        rf;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        DOWNCOUNTER = 1'b0;
   logic [11:0] COLOR_IN = 12'h000;

   logic [9:0]  addrh_a, addrh_b;
   logic [8:0]  addrv_a, addrv_b;
   logic [11:0] color_a, color_b;
   logic        hs_a, hs_b, vs_a, vs_b, rf_a, rf_b;

   int   checks = 0;
   int   failures = 0;
   exp_t qa[$];
   exp_t qb[$];

   // model state: pixel index within the frame plus registered outputs
   int          pix[2];
   logic [11:0] mcol[2];
   logic        mhs[2], mvs[2], mrf[2];
   int          p_h[2][4] = '{'{640, 16, 96, 48}, '{16, 4, 6, 4}};
   int          p_v[2][4] = '{'{480, 10, 2, 33}, '{10, 2, 2, 3}};

   bit   measure_on = 1'b0;
   int   cyc = 0;
   int   a_low = 0, a_falls = 0, a_last_fall = 0;
   int   b_low = 0, b_falls = 0, b_last_rf = 0;
   bit   b_rf_seen = 1'b0;
   logic a_prev_hs = 1'b1, b_prev_vs = 1'b1, b_prev_rf = 1'b0;

   always #10 CLK = ~CLK;

   vga_interface dut_a (
      .CLK(CLK), .RST(RST), .DOWNCOUNTER(DOWNCOUNTER), .COLOR_IN(COLOR_IN),
      .ADDRH(addrh_a), .ADDRV(addrv_a), .COLOR_OUT(color_a),
      .HS(hs_a), .VS(vs_a), .REFRESH(rf_a)
   );

   vga_interface #(
      .H_VISIBLE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
      .V_VISIBLE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) dut_b (
      .CLK(CLK), .RST(RST), .DOWNCOUNTER(DOWNCOUNTER), .COLOR_IN(COLOR_IN),
      .ADDRH(addrh_b), .ADDRV(addrv_b), .COLOR_OUT(color_b),
      .HS(hs_b), .VS(vs_b), .REFRESH(rf_b)
   );

   task automatic chk(input string name, input int act, input int want);
      checks++;
      if (act != want) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic cmp(input string name, input exp_t want, input exp_t act);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s cycle %0d: got h=%0d v=%0d c=%h hs=%b vs=%b rf=%b, expected h=%0d v=%0d c=%h hs=%b vs=%b rf=%b",
                  name, cyc, act.h, act.v, act.c, act.hs, act.vs, act.rf,
                  want.h, want.v, want.c, want.hs, want.vs, want.rf);
      end
   endtask

   // expected outputs after the coming edge, from the pixel index within the frame
   task automatic model(input int i, output exp_t e);
      int ht, ft, x, y;
      ht = p_h[i][0] + p_h[i][1] + p_h[i][2] + p_h[i][3];
      ft = ht * (p_v[i][0] + p_v[i][1] + p_v[i][2] + p_v[i][3]);
      if (RST) begin
         pix[i] = 0; mcol[i] = 12'h000; mhs[i] = 1'b1; mvs[i] = 1'b1; mrf[i] = 1'b0;
      end else if (DOWNCOUNTER) begin
         x = pix[i] % ht;
         y = pix[i] / ht;
         mcol[i] = (x < p_h[i][0] && y < p_v[i][0]) ? COLOR_IN : 12'h000;
         mhs[i]  = !(x >= p_h[i][0] + p_h[i][1] && x < p_h[i][0] + p_h[i][1] + p_h[i][2]);
         mvs[i]  = !(y >= p_v[i][0] + p_v[i][1] && y < p_v[i][0] + p_v[i][1] + p_v[i][2]);
         pix[i]  = (pix[i] + 1) % ft;
         mrf[i]  = (pix[i] == 0);
      end else begin
         mrf[i] = 1'b0;
      end
      e.h  = 10'(pix[i] % ht);
      e.v  = 9'(pix[i] / ht);
      e.c  = mcol[i];
      e.hs = mhs[i];
      e.vs = mvs[i];
      e.rf = mrf[i];
   endtask

   task automatic drive(input logic rst, input logic en, input logic [11:0] col);
      exp_t e;
      @(negedge CLK);
      RST = rst;
      DOWNCOUNTER = en;
      COLOR_IN = col;
      model(0, e);
      qa.push_back(e);
      model(1, e);
      qb.push_back(e);
   endtask

   // monitor: scoreboard pops every cycle, plus sync/frame timing measurements
   always begin
      @(posedge CLK);
      #5;
      cyc = cyc + 1;
      if (qa.size() > 0) cmp("pixel_a", qa.pop_front(), {addrh_a, addrv_a, color_a, hs_a, vs_a, rf_a});
      if (qb.size() > 0) cmp("pixel_b", qb.pop_front(), {addrh_b, addrv_b, color_b, hs_b, vs_b, rf_b});
      if (measure_on) begin
         if (a_prev_hs === 1'b1 && hs_a === 1'b0) begin
            chk("hs_fall_addrh", int'(addrh_a), 657);
            if (a_falls > 0) chk("hs_fall_spacing", cyc - a_last_fall, 1600);
            a_falls++;
            a_last_fall = cyc;
            a_low = 0;
         end
         if (hs_a === 1'b0) a_low++;
         if (a_prev_hs === 1'b0 && hs_a === 1'b1 && a_falls > 0) chk("hs_low_width", a_low, 192);
         if (b_prev_vs === 1'b1 && vs_b === 1'b0) begin
            b_falls++;
            b_low = 0;
         end
         if (vs_b === 1'b0) b_low++;
         if (b_prev_vs === 1'b0 && vs_b === 1'b1 && b_falls > 0) chk("vs_low_width", b_low, 120);
         if (b_prev_rf === 1'b1) chk("refresh_width", int'(rf_b), 0);
         if (rf_b === 1'b1) begin
            chk("refresh_addr", int'({addrh_b, addrv_b}), 0);
            if (b_rf_seen) chk("refresh_spacing", cyc - b_last_rf, 1020);
            b_rf_seen = 1'b1;
            b_last_rf = cyc;
         end
      end
      a_prev_hs = hs_a;
      b_prev_vs = vs_b;
      b_prev_rf = rf_b;
   end

   initial begin
      logic [11:0] pat;
      logic        tgl;
      pat = 12'h3A5;
      tgl = 1'b0;
      // reset held with the enable toggling and white on the color bus
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, tgl, 12'hFFF);
         tgl = ~tgl;
      end
      // nominal run: constant color, then a changing pattern
      measure_on = 1'b1;
      tgl = 1'b1;
      for (int k = 0; k < 3400; k++) begin
         drive(1'b0, tgl, (k < 1700) ? 12'hABC : pat);
         tgl = ~tgl;
         pat = pat + 12'h2D7;
      end
      measure_on = 1'b0;
      // enable held low mid-line
      for (int k = 0; k < 100; k++) begin
         drive(1'b0, 1'b0, pat);
         pat = pat + 12'h111;
      end
      // run to hcnt=300 on the full-size instance, then a one-cycle reset
      for (int k = 0; k < 2000 && (pix[0] % 800) != 300; k++) begin
         drive(1'b0, tgl, pat);
         tgl = ~tgl;
         pat = pat + 12'h2D7;
      end
      drive(1'b1, tgl, 12'hFFF);
      tgl = 1'b1;
      for (int k = 0; k < 200; k++) begin
         drive(1'b0, tgl, pat);
         tgl = ~tgl;
         pat = pat + 12'h2D7;
      end
      @(posedge CLK);
      #7;
      chk("queue_a_drained", qa.size(), 0);
      chk("queue_b_drained", qb.size(), 0);
      chk("hs_falls_seen", (a_falls >= 2) ? 1 : 0, 1);
      chk("refresh_seen", b_rf_seen ? 1 : 0, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vga_interface.md
# vga_interface

VGA 640x480 @ 60 Hz timing generator and pixel output stage. It runs on the 50 MHz system clock and advances one pixel on each cycle where the 25 MHz pixel enable is high. It publishes the current pixel coordinate so the upstream frame compositor can fetch a 12-bit RGB color. It then drives that color, blanked outside the visible area, to the VGA port together with HS and VS.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels); line total is 800
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines); frame total is 525

Ports:
- One clock; reset is synchronous and active-high.
- CLK  in  1  system clock, 50 MHz
- RST  in  1  synchronous active-high reset; tie low if unused
- DOWNCOUNTER  in  1  pixel enable; pixel state advances only on CLK edges where it is 1 (a 25 MHz square wave gives a 25 MHz pixel rate)
- COLOR_IN  in  12  RGB 4:4:4 for the pixel at ADDRH/ADDRV; sampled on enabled edges
- ADDRH  out  10  horizontal counter, 0..799
- ADDRV  out  9  vertical counter low 9 bits, 0..511 (aliases for lines 512..524)
- COLOR_OUT  out  12  RGB to VGA DAC
- HS  out  1  horizontal sync, active low
- VS  out  1  vertical sync, active low
- REFRESH  out  1  one-CLK pulse at start of each frame

## Operation
- hcnt (10 b) and vcnt (10 b) are registers that update only on enabled edges (RST=0, DOWNCOUNTER=1).
- hcnt increments and wraps 799→0. On that wrap vcnt increments and wraps 524→0.
- ADDRH = hcnt and ADDRV = vcnt[8:0], both combinational from the registers.
- visible = (hcnt < 640) && (vcnt < 480), evaluated on the current counters.
- On each enabled edge these outputs register:
  - COLOR_OUT ← visible ? COLOR_IN : 12'h000
  - HS ← ~(656 ≤ hcnt ≤ 751)
  - VS ← ~(490 ≤ vcnt ≤ 491)
- REFRESH = 1 for exactly one CLK cycle, immediately after the enabled edge where hcnt 799→0 and vcnt 524→0. It is 0 otherwise, including on non-enabled cycles.
- On non-enabled edges, counters, COLOR_OUT, HS and VS hold.
- Sync boundaries derive from the parameters: HS low for H_SYNC pixels starting at H_VISIBLE+H_FP; VS low for V_SYNC lines starting at V_VISIBLE+V_FP.

## Timing
- Reset values: hcnt=0, vcnt=0 (so ADDRH=0, ADDRV=0), COLOR_OUT=0, HS=1, VS=1, REFRESH=0.
- RST dominates DOWNCOUNTER. Asserting RST mid-frame restarts the frame at (0,0) on the next CLK edge, with no REFRESH pulse.
- The first enabled edge after reset release outputs pixel (0,0) and advances the counters to (1,0).
- Address-to-color latency is one pixel:
  - ADDRH/ADDRV change on enabled edge N.
  - COLOR_IN must be valid by enabled edge N+1, i.e. within 2 CLK at the nominal enable rate (one CLK of compositor latency is allowed).
  - COLOR_OUT, HS and VS for that pixel appear after edge N+1 and stay mutually aligned.
- Line = 800 enabled edges; frame = 420000 enabled edges = 840000 CLK at the nominal enable.
- Visible→blank transition: pixel hcnt=639 is the last one driven. At hcnt=640, COLOR_OUT=0 is registered regardless of COLOR_IN.

## Test plan
- Reset: hold RST 3 cycles with DOWNCOUNTER toggling, COLOR_IN=12'hFFF -> ADDRH=0, ADDRV=0, COLOR_OUT=0, HS=1, VS=1, REFRESH=0 throughout.
- Horizontal sync: toggle DOWNCOUNTER each CLK -> HS low for exactly 192 CLK; falling edges 1600 CLK apart; first HS fall registered on the enabled edge seeing hcnt=656.
- Vertical sync and frame: run a full frame -> VS low for 2 lines (3200 CLK); REFRESH is a single-CLK pulse every 840000 CLK; ADDRV after the 525th line wrap is 0.
- Blanking: drive COLOR_IN=12'hABC constant -> COLOR_OUT=12'hABC only for hcnt 0..639 / vcnt 0..479 (one pixel delayed); 12'h000 at hcnt 640..799 and on lines 480..524.
- Enable hold: hold DOWNCOUNTER=0 for 100 CLK mid-line -> ADDRH, ADDRV, COLOR_OUT, HS and VS unchanged; REFRESH stays 0.
- Mid-frame reset: assert RST for 1 CLK at (hcnt=300, vcnt=200) -> next cycle ADDRH=0, ADDRV=0, HS=VS=1, COLOR_OUT=0, no REFRESH pulse.
